ccx_ic_arbiter: RTL and testbench

Two-master to one-slave arbiter for the core complex interconnect. Merges the CPU instruction port and the CPU data port onto a single core_mem_bus request port, which drives the address router's core-side port directly. Keeps each granted transaction's owner so the one-cycle-later response goes back to the correct master. Holds its selection stable while a slave stalls.

---
 rtl/ccx_ic_arbiter.sv | 153 +++++++++++++++
 tb/tb_ccx_ic_arbiter.sv | 288 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ccx_ic_arbiter.sv
// Two-master (imem/dmem) to one-slave request arbiter with lock-on-stall and response routing.
// Optional CCX_IC_ARB_RR_EN: round-robin between simultaneous requesters instead of dmem priority.
module ccx_ic_arbiter #(
    parameter int unsigned AW = 39,
    parameter int unsigned DW = 64
) (
    input  logic              g_clk,
    input  logic              g_reset,
    // instruction master
    input  logic              imem_req_i,
    output logic              imem_gnt_o,
    input  logic              imem_wen_i,
    input  logic [DW/8-1:0]   imem_strb_i,
    input  logic [DW-1:0]     imem_wdata_i,
    input  logic [AW-1:0]     imem_addr_i,
    output logic [DW-1:0]     imem_rdata_o,
    output logic              imem_err_o,
    // data master
    input  logic              dmem_req_i,
    output logic              dmem_gnt_o,
    input  logic              dmem_wen_i,
    input  logic [DW/8-1:0]   dmem_strb_i,
    input  logic [DW-1:0]     dmem_wdata_i,
    input  logic [AW-1:0]     dmem_addr_i,
    output logic [DW-1:0]     dmem_rdata_o,
    output logic              dmem_err_o,
    // merged port toward the router
    output logic              out_req_o,
    input  logic              out_gnt_i,
    output logic              out_wen_o,
    output logic [DW/8-1:0]   out_strb_o,
    output logic [DW-1:0]     out_wdata_o,
    output logic [AW-1:0]     out_addr_o,
    input  logic [DW-1:0]     out_rdata_i,
    input  logic              out_err_i
);

    localparam logic MST_IMEM = 1'b0;
    localparam logic MST_DMEM = 1'b1;

    typedef enum logic {
        ST_UNLOCKED = 1'b0,
        ST_LOCKED   = 1'b1
    } state_e;

    state_e state_q, state_d;
    logic   owner_q, owner_d;
    logic   rsp_vld_q, rsp_vld_d;
    logic   rsp_own_q, rsp_own_d;
    logic   sel;
    logic   accept;

`ifdef CCX_IC_ARB_RR_EN
    logic last_win_q, last_win_d;
`endif

    // Selection: a locked owner is never pre-empted.
    always_comb begin
        sel = MST_IMEM;
        if (state_q == ST_LOCKED) begin
            sel = owner_q;
        end else if (imem_req_i && dmem_req_i) begin
`ifdef CCX_IC_ARB_RR_EN
            sel = ~last_win_q;
`else
            sel = MST_DMEM;
`endif
        end else begin
            sel = dmem_req_i ? MST_DMEM : MST_IMEM;
        end
    end

    // Request path forwarding and grant gating.
    always_comb begin
        out_req_o   = (sel == MST_DMEM) ? dmem_req_i   : imem_req_i;
        out_wen_o   = (sel == MST_DMEM) ? dmem_wen_i   : imem_wen_i;
        out_strb_o  = (sel == MST_DMEM) ? dmem_strb_i  : imem_strb_i;
        out_wdata_o = (sel == MST_DMEM) ? dmem_wdata_i : imem_wdata_i;
        out_addr_o  = (sel == MST_DMEM) ? dmem_addr_i  : imem_addr_i;
        imem_gnt_o  = (sel == MST_IMEM) && imem_req_i && out_gnt_i;
        dmem_gnt_o  = (sel == MST_DMEM) && dmem_req_i && out_gnt_i;
        accept      = out_req_o && out_gnt_i;
    end

    // Response path: only the master that owned the previous acceptance sees rdata/err.
    always_comb begin
        imem_rdata_o = '0;
        imem_err_o   = 1'b0;
        dmem_rdata_o = '0;
        dmem_err_o   = 1'b0;
        if (rsp_vld_q) begin
            if (rsp_own_q == MST_DMEM) begin
                dmem_rdata_o = out_rdata_i;
                dmem_err_o   = out_err_i;
            end else begin
                imem_rdata_o = out_rdata_i;
                imem_err_o   = out_err_i;
            end
        end
    end

    // Lock FSM next-state and routing-state updates.
    always_comb begin
        state_d   = state_q;
        owner_d   = owner_q;
        rsp_vld_d = accept;
        rsp_own_d = accept ? sel : rsp_own_q;
        case (state_q)
            ST_UNLOCKED: begin
                if (out_req_o && !out_gnt_i) begin
                    state_d = ST_LOCKED;
                    owner_d = sel;
                end
            end
            ST_LOCKED: begin
                // Owner dropping req is a protocol violation; unlock and carry on.
                if (!out_req_o || out_gnt_i) begin
                    state_d = ST_UNLOCKED;
                end
            end
            default: state_d = ST_UNLOCKED;
        endcase
    end

    always_ff @(posedge g_clk or posedge g_reset) begin
        if (g_reset) begin
            state_q   <= ST_UNLOCKED;
            owner_q   <= MST_IMEM;
            rsp_vld_q <= 1'b0;
            rsp_own_q <= MST_IMEM;
        end else begin
            state_q   <= state_d;
            owner_q   <= owner_d;
            rsp_vld_q <= rsp_vld_d;
            rsp_own_q <= rsp_own_d;
        end
    end

`ifdef CCX_IC_ARB_RR_EN
    always_comb begin
        last_win_d = accept ? sel : last_win_q;
    end

    always_ff @(posedge g_clk or posedge g_reset) begin
        if (g_reset) begin
            last_win_q <= MST_DMEM;
        end else begin
            last_win_q <= last_win_d;
        end
    end
`endif

endmodule

// File: tb/tb_ccx_ic_arbiter.sv
// Directed self-checking bench for ccx_ic_arbiter; inputs driven on negedge, outputs sampled 1ns later.
module tb_ccx_ic_arbiter;

    localparam int unsigned AW = 39;
    localparam int unsigned DW = 64;

    logic            g_clk;
    logic            g_reset;
    logic            imem_req, imem_gnt, imem_wen, imem_err;
    logic [DW/8-1:0] imem_strb;
    logic [DW-1:0]   imem_wdata, imem_rdata;
    logic [AW-1:0]   imem_addr;
    logic            dmem_req, dmem_gnt, dmem_wen, dmem_err;
    logic [DW/8-1:0] dmem_strb;
    logic [DW-1:0]   dmem_wdata, dmem_rdata;
    logic [AW-1:0]   dmem_addr;
    logic            out_req, out_gnt, out_wen, out_err;
    logic [DW/8-1:0] out_strb;
    logic [DW-1:0]   out_wdata, out_rdata;
    logic [AW-1:0]   out_addr;

    int total;
    int bad;

    ccx_ic_arbiter #(.AW(AW), .DW(DW)) dut (
        .g_clk        (g_clk),
        .g_reset      (g_reset),
        .imem_req_i   (imem_req),
        .imem_gnt_o   (imem_gnt),
        .imem_wen_i   (imem_wen),
        .imem_strb_i  (imem_strb),
        .imem_wdata_i (imem_wdata),
        .imem_addr_i  (imem_addr),
        .imem_rdata_o (imem_rdata),
        .imem_err_o   (imem_err),
        .dmem_req_i   (dmem_req),
        .dmem_gnt_o   (dmem_gnt),
        .dmem_wen_i   (dmem_wen),
        .dmem_strb_i  (dmem_strb),
        .dmem_wdata_i (dmem_wdata),
        .dmem_addr_i  (dmem_addr),
        .dmem_rdata_o (dmem_rdata),
        .dmem_err_o   (dmem_err),
        .out_req_o    (out_req),
        .out_gnt_i    (out_gnt),
        .out_wen_o    (out_wen),
        .out_strb_o   (out_strb),
        .out_wdata_o  (out_wdata),
        .out_addr_o   (out_addr),
        .out_rdata_i  (out_rdata),
        .out_err_i    (out_err)
    );

    initial begin
        g_clk = 1'b0;
        forever #5 g_clk = ~g_clk;
    end

    task automatic clr();
        imem_req = 1'b0; imem_wen = 1'b0; imem_strb = '0; imem_wdata = '0; imem_addr = '0;
        dmem_req = 1'b0; dmem_wen = 1'b0; dmem_strb = '0; dmem_wdata = '0; dmem_addr = '0;
        out_gnt = 1'b0; out_rdata = '0; out_err = 1'b0;
    endtask

    task automatic test_reset();
        g_reset = 1'b1;
        clr();
        out_gnt = 1'b1;
        out_rdata = 64'hDEAD_BEEF_0000_0001;
        out_err = 1'b1;
        @(negedge g_clk); #1;
        total++; if (out_req !== 1'b0) begin bad++; $display("FAIL rst_out_req got=%0h exp=0", out_req); end
        total++; if (imem_gnt !== 1'b0 || dmem_gnt !== 1'b0) begin bad++; $display("FAIL rst_gnt got=%0h/%0h exp=0/0", imem_gnt, dmem_gnt); end
        total++; if (imem_rdata !== '0 || dmem_rdata !== '0) begin bad++; $display("FAIL rst_rdata got=%0h/%0h exp=0/0", imem_rdata, dmem_rdata); end
        total++; if (imem_err !== 1'b0 || dmem_err !== 1'b0) begin bad++; $display("FAIL rst_err got=%0h/%0h exp=0/0", imem_err, dmem_err); end
        @(negedge g_clk);
        g_reset = 1'b0;
        clr();
    endtask

    task automatic test_imem_only();
        @(negedge g_clk);
        clr();
        imem_req = 1'b1; imem_addr = 39'h10000; out_gnt = 1'b1;
        #1;
        total++; if (imem_gnt !== 1'b1) begin bad++; $display("FAIL imem_only_gnt got=%0h exp=1", imem_gnt); end
        total++; if (dmem_gnt !== 1'b0) begin bad++; $display("FAIL imem_only_dgnt got=%0h exp=0", dmem_gnt); end
        total++; if (out_addr !== 39'h10000 || out_req !== 1'b1) begin bad++; $display("FAIL imem_only_fwd got=%0h/%0h exp=10000/1", out_addr, out_req); end
        @(negedge g_clk);
        imem_req = 1'b0; out_rdata = 64'h1122334455667788;
        #1;
        total++; if (imem_rdata !== 64'h1122334455667788) begin bad++; $display("FAIL imem_only_rdata got=%0h exp=1122334455667788", imem_rdata); end
        total++; if (dmem_rdata !== '0 || dmem_gnt !== 1'b0) begin bad++; $display("FAIL imem_only_dmem got=%0h/%0h exp=0/0", dmem_rdata, dmem_gnt); end
        @(negedge g_clk);
        clr();
        #1;
        total++; if (imem_rdata !== '0) begin bad++; $display("FAIL imem_only_idle got=%0h exp=0", imem_rdata); end
    endtask

    task automatic test_priority();
        @(negedge g_clk);
        clr();
        imem_req = 1'b1; imem_addr = 39'h100; dmem_req = 1'b1; dmem_addr = 39'h200; out_gnt = 1'b1;
        #1;
        total++; if (dmem_gnt !== 1'b1 || imem_gnt !== 1'b0) begin bad++; $display("FAIL prio_c0 got=%0h/%0h exp=d1/i0", dmem_gnt, imem_gnt); end
        total++; if (out_addr !== 39'h200) begin bad++; $display("FAIL prio_c0_addr got=%0h exp=200", out_addr); end
        @(negedge g_clk);
        dmem_req = 1'b0; out_rdata = 64'hD1;
        #1;
        total++; if (imem_gnt !== 1'b1 || out_addr !== 39'h100) begin bad++; $display("FAIL prio_c1_igrant got=%0h/%0h exp=1/100", imem_gnt, out_addr); end
        total++; if (dmem_rdata !== 64'hD1 || imem_rdata !== '0) begin bad++; $display("FAIL prio_c1_rsp got=%0h/%0h exp=d1/0", dmem_rdata, imem_rdata); end
        @(negedge g_clk);
        imem_req = 1'b0; out_rdata = 64'hA1;
        #1;
        total++; if (imem_rdata !== 64'hA1 || dmem_rdata !== '0) begin bad++; $display("FAIL prio_c2_rsp got=%0h/%0h exp=a1/0", imem_rdata, dmem_rdata); end
        @(negedge g_clk);
        clr();
    endtask

    task automatic test_stall();
        @(negedge g_clk);
        clr();
        imem_req = 1'b1; imem_addr = 39'h300;
        #1;
        total++; if (imem_gnt !== 1'b0 || out_addr !== 39'h300) begin bad++; $display("FAIL stall_c0 got=%0h/%0h exp=0/300", imem_gnt, out_addr); end
        for (int c = 1; c < 3; c++) begin
            @(negedge g_clk);
            dmem_req = 1'b1; dmem_addr = 39'h400;
            #1;
            total++; if (out_addr !== 39'h300 || dmem_gnt !== 1'b0) begin bad++; $display("FAIL stall_hold c%0d got=%0h/%0h exp=300/0", c, out_addr, dmem_gnt); end
        end
        @(negedge g_clk);
        out_gnt = 1'b1;
        #1;
        total++; if (imem_gnt !== 1'b1 || dmem_gnt !== 1'b0 || out_addr !== 39'h300) begin bad++; $display("FAIL stall_c3 got=%0h/%0h/%0h exp=1/0/300", imem_gnt, dmem_gnt, out_addr); end
        @(negedge g_clk);
        imem_req = 1'b0; out_rdata = 64'hB3;
        #1;
        total++; if (dmem_gnt !== 1'b1 || out_addr !== 39'h400) begin bad++; $display("FAIL stall_c4 got=%0h/%0h exp=1/400", dmem_gnt, out_addr); end
        total++; if (imem_rdata !== 64'hB3 || dmem_rdata !== '0) begin bad++; $display("FAIL stall_c4_rsp got=%0h/%0h exp=b3/0", imem_rdata, dmem_rdata); end
        @(negedge g_clk);
        dmem_req = 1'b0; out_rdata = 64'hB4;
        #1;
        total++; if (dmem_rdata !== 64'hB4 || imem_rdata !== '0) begin bad++; $display("FAIL stall_c5_rsp got=%0h/%0h exp=b4/0", dmem_rdata, imem_rdata); end
        @(negedge g_clk);
        clr();
    endtask

    task automatic test_err();
        @(negedge g_clk);
        clr();
        dmem_req = 1'b1; dmem_wen = 1'b1; dmem_strb = 8'hFF; dmem_wdata = 64'hCAFE_F00D_0123_4567; dmem_addr = 39'h500;
        out_gnt = 1'b1;
        #1;
        total++; if (out_wen !== 1'b1 || out_strb !== 8'hFF || out_wdata !== 64'hCAFE_F00D_0123_4567) begin bad++; $display("FAIL err_fwd got=%0h/%0h/%0h exp=1/ff/cafef00d01234567", out_wen, out_strb, out_wdata); end
        total++; if (dmem_gnt !== 1'b1) begin bad++; $display("FAIL err_dgnt got=%0h exp=1", dmem_gnt); end
        @(negedge g_clk);
        dmem_req = 1'b0; dmem_wen = 1'b0;
        imem_req = 1'b1; imem_addr = 39'h600; out_err = 1'b1;
        #1;
        total++; if (dmem_err !== 1'b1 || imem_err !== 1'b0) begin bad++; $display("FAIL err_c1 got=%0h/%0h exp=d1/i0", dmem_err, imem_err); end
        total++; if (imem_gnt !== 1'b1 || out_wen !== 1'b0) begin bad++; $display("FAIL err_c1_igrant got=%0h/%0h exp=1/0", imem_gnt, out_wen); end
        @(negedge g_clk);
        imem_req = 1'b0; out_rdata = 64'hE2; out_err = 1'b1;
        #1;
        total++; if (imem_err !== 1'b1 || imem_rdata !== 64'hE2 || dmem_err !== 1'b0) begin bad++; $display("FAIL err_c2 got=%0h/%0h/%0h exp=1/e2/0", imem_err, imem_rdata, dmem_err); end
        @(negedge g_clk);
        clr();
        out_err = 1'b1;
        #1;
        total++; if (imem_err !== 1'b0 || dmem_err !== 1'b0) begin bad++; $display("FAIL err_idle got=%0h/%0h exp=0/0", imem_err, dmem_err); end
        @(negedge g_clk);
        clr();
    endtask

    task automatic test_drop();
        @(negedge g_clk);
        clr();
        imem_req = 1'b1; imem_addr = 39'h700;
        @(negedge g_clk);
        imem_req = 1'b0; dmem_req = 1'b1; dmem_addr = 39'h800; out_gnt = 1'b1;
        #1;
        total++; if (out_req !== 1'b0 || dmem_gnt !== 1'b0) begin bad++; $display("FAIL drop_locked got=%0h/%0h exp=0/0", out_req, dmem_gnt); end
        @(negedge g_clk);
        #1;
        total++; if (dmem_gnt !== 1'b1 || out_addr !== 39'h800) begin bad++; $display("FAIL drop_recover got=%0h/%0h exp=1/800", dmem_gnt, out_addr); end
        @(negedge g_clk);
        clr();
        out_gnt = 1'b1; out_rdata = 64'h77;
        #1;
        total++; if (out_req !== 1'b0 || imem_gnt !== 1'b0 || dmem_gnt !== 1'b0) begin bad++; $display("FAIL gnt_noreq got=%0h/%0h/%0h exp=0/0/0", out_req, imem_gnt, dmem_gnt); end
        @(negedge g_clk);
        #1;
        total++; if (imem_rdata !== '0 || dmem_rdata !== '0) begin bad++; $display("FAIL gnt_noreq_rsp got=%0h/%0h exp=0/0", imem_rdata, dmem_rdata); end
        clr();
    endtask

    task automatic test_reset_mid();
        logic [AW-1:0] exp_addr;
        // pending response discarded
        @(negedge g_clk);
        clr();
        dmem_req = 1'b1; dmem_addr = 39'h900; out_gnt = 1'b1;
        @(negedge g_clk);
        dmem_req = 1'b0; out_rdata = 64'h99;
        #1;
        total++; if (dmem_rdata !== 64'h99) begin bad++; $display("FAIL rstmid_pre got=%0h exp=99", dmem_rdata); end
        g_reset = 1'b1;
        #1;
        total++; if (dmem_rdata !== '0 || imem_rdata !== '0) begin bad++; $display("FAIL rstmid_rsp got=%0h/%0h exp=0/0", dmem_rdata, imem_rdata); end
        @(negedge g_clk);
        g_reset = 1'b0;
        #1;
        total++; if (dmem_rdata !== '0 || imem_rdata !== '0) begin bad++; $display("FAIL rstmid_stray got=%0h/%0h exp=0/0", dmem_rdata, imem_rdata); end
        // lock cleared
        @(negedge g_clk);
        clr();
        imem_req = 1'b1; imem_addr = 39'hA00;
        @(negedge g_clk);
        dmem_req = 1'b1; dmem_addr = 39'hB00;
        #1;
        total++; if (out_addr !== 39'hA00) begin bad++; $display("FAIL rstmid_locked got=%0h exp=a00", out_addr); end
        g_reset = 1'b1;
        #1;
`ifdef CCX_IC_ARB_RR_EN
        exp_addr = 39'hA00;
`else
        exp_addr = 39'hB00;
`endif
        total++; if (out_addr !== exp_addr) begin bad++; $display("FAIL rstmid_unlock got=%0h exp=%0h", out_addr, exp_addr); end
        @(negedge g_clk);
        g_reset = 1'b0; out_gnt = 1'b1;
        #1;
        total++; if (out_addr !== exp_addr || out_req !== 1'b1) begin bad++; $display("FAIL rstmid_fresh got=%0h/%0h exp=%0h/1", out_addr, out_req, exp_addr); end
        @(negedge g_clk);
        clr();
    endtask

    task automatic test_back_to_back();
        logic exp_d;
        logic prev_d;
        @(negedge g_clk);
        clr();
        g_reset = 1'b1;
        @(negedge g_clk);
        g_reset = 1'b0;
        prev_d = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge g_clk);
            imem_req = 1'b1; imem_addr = 39'h1000; dmem_req = 1'b1; dmem_addr = 39'h2000; out_gnt = 1'b1;
            out_rdata = 64'hA0 + 64'(i);
`ifdef CCX_IC_ARB_RR_EN
            exp_d = (i % 2) == 1;
`else
            exp_d = 1'b1;
`endif
            #1;
            total++; if (dmem_gnt !== exp_d || imem_gnt !== !exp_d) begin bad++; $display("FAIL b2b_win c%0d got=d%0h/i%0h exp=d%0h", i, dmem_gnt, imem_gnt, exp_d); end
            if (i > 0) begin
                total++;
                if ((prev_d ? dmem_rdata : imem_rdata) !== 64'hA0 + 64'(i) || (prev_d ? imem_rdata : dmem_rdata) !== '0) begin
                    bad++; $display("FAIL b2b_rsp c%0d got=d%0h/i%0h exp_owner_d=%0h val=%0h", i, dmem_rdata, imem_rdata, prev_d, 64'hA0 + 64'(i));
                end
            end
            prev_d = exp_d;
        end
        @(negedge g_clk);
        clr();
    endtask

    initial begin
        total = 0;
        bad = 0;
        g_reset = 1'b1;
        clr();
        test_reset();
        test_imem_only();
        test_priority();
        test_stall();
        test_err();
        test_drop();
        test_reset_mid();
        test_back_to_back();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
